// File: rtl/tpg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tpg_pkg: pattern mode encodings and the colour-bar lookup.      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package tpg_pkg;

  typedef enum logic [1:0] {
    TPG_SCROLL = 2'd0,
    TPG_BARS   = 2'd1,
    TPG_CHECK  = 2'd2,
    TPG_SOLID  = 2'd3
  } tpg_mode_e;

  // Returns {R,G,B} on/off flags: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return {~idx[1], ~idx[2], ~idx[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/test_pattern_gen_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | test_pattern_gen_if: pixel request / RGB response bundle.       |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface test_pattern_gen_if #(
  parameter int CW = 8
);
  logic          req_en;
  logic          req_sof;
  logic          req_sol;
  logic [CW-1:0] resp_red;
  logic [CW-1:0] resp_green;
  logic [CW-1:0] resp_blue;
  logic          resp_valid;

  modport master (
    output req_en, req_sof, req_sol,
    input  resp_red, resp_green, resp_blue, resp_valid
  );

  modport slave (
    input  req_en, req_sof, req_sol,
    output resp_red, resp_green, resp_blue, resp_valid
  );
endinterface
`default_nettype wire

// File: rtl/resp_delay_line.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | resp_delay_line: free-running shift register, DEPTH >= 0.       |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module resp_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/test_pattern_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | test_pattern_gen: frame-locked RGB pattern source answering the |
// | HDMI TX pixel requests after RESP_LATENCY cycles.    Rev 1.0    |
// +-----------------------------------------------------------------+
module test_pattern_gen
  import tpg_pkg::*;
#(
  parameter int CW           = 8,
  parameter int RESP_LATENCY = 1,
  parameter int XW           = 12,
  parameter int BAR_LOG2     = 7,
  parameter int CHK_LOG2     = 5
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic [1:0]      mode,
  input  wire logic [3*CW-1:0] solid_rgb,
  input  wire logic [CW-1:0]   scroll_step,
  test_pattern_gen_if.slave    bus,
  output logic [15:0]          frame_cnt
);

  localparam logic [XW-1:0] XMAX = '1;
  localparam int            DW   = 3*CW + 1;

  logic            sof, sol;
  logic [XW-1:0]   x_q, y_q, x_d, y_d;
  logic [CW-1:0]   off_q, off_cur_q, off_e;
  tpg_mode_e       mode_q, mode_e;
  logic [3*CW-1:0] solid_q, rgb_e;
  logic [CW-1:0]   step_q, step_e;
  logic [15:0]     frame_cnt_q;
  logic [3*CW-1:0] col_q, col_d;
  logic            vld_q;
  logic [CW-1:0]   g;
  logic [2:0]      bar;
  logic            chk;
  logic [DW-1:0]   s1, sl;

  assign sof = bus.req_sof;
  assign sol = bus.req_sol & ~bus.req_sof;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (sof || sol)       x_d = '0;
    else if (x_q != XMAX) x_d = x_q + 1'b1;
    if (sof)                     y_d = '0;
    else if (sol && y_q != XMAX) y_d = y_q + 1'b1;
  end

  // off_q already points at the next frame; the running frame keeps its own copy.
  assign mode_e = sof ? tpg_mode_e'(mode) : mode_q;
  assign rgb_e  = sof ? solid_rgb : solid_q;
  assign step_e = sof ? scroll_step : step_q;
  assign off_e  = sof ? off_q : off_cur_q;

  assign g   = off_e + CW'(x_d) + CW'(y_d);
  assign bar = bar_rgb(x_d[BAR_LOG2+2:BAR_LOG2]);
  assign chk = x_d[CHK_LOG2] ^ y_d[CHK_LOG2];

  always_comb begin
    col_d = '0;
    case (mode_e)
      TPG_SCROLL: col_d = {g, ~g, g};
      TPG_BARS:   col_d = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
      TPG_CHECK:  col_d = {3*CW{~chk}};
      TPG_SOLID:  col_d = rgb_e;
      default:    col_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      off_q       <= '0;
      off_cur_q   <= '0;
      mode_q      <= TPG_SCROLL;
      solid_q     <= '0;
      step_q      <= '0;
      frame_cnt_q <= '0;
      col_q       <= '0;
      vld_q       <= 1'b0;
    end else begin
      vld_q <= bus.req_en;
      if (bus.req_en) begin
        x_q   <= x_d;
        y_q   <= y_d;
        col_q <= col_d;
        if (sof) begin
          mode_q      <= mode_e;
          solid_q     <= rgb_e;
          step_q      <= step_e;
          off_cur_q   <= off_q;
          off_q       <= off_q + step_e;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
      end
    end
  end

  assign s1 = {vld_q, col_q};

  generate
    if (RESP_LATENCY > 1) begin : g_delay
      resp_delay_line #(
        .WIDTH(DW),
        .DEPTH(RESP_LATENCY - 1)
      ) u_delay (
        .clk(clk),
        .rst(rst),
        .d_i(s1),
        .q_o(sl)
      );
    end else begin : g_nodelay
      assign sl = s1;
    end
  endgenerate

  assign bus.resp_valid = sl[DW-1];
  assign bus.resp_red   = sl[3*CW-1:2*CW];
  assign bus.resp_green = sl[2*CW-1:CW];
  assign bus.resp_blue  = sl[CW-1:0];
  assign frame_cnt      = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_test_pattern_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_test_pattern_gen: two instances (latency 1 and 3) driven in  |
// | lockstep against a frame/pixel level colour model.   Rev 1.0    |
// +-----------------------------------------------------------------+
module tb_test_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [7:0]  scroll_step;
  logic [15:0] fc_a, fc_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  test_pattern_gen_if #(.CW(8)) ifa ();
  test_pattern_gen_if #(.CW(8)) ifb ();

  test_pattern_gen #(.CW(8), .RESP_LATENCY(1), .XW(12), .BAR_LOG2(2), .CHK_LOG2(1)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
    .scroll_step(scroll_step), .bus(ifa), .frame_cnt(fc_a)
  );

  test_pattern_gen #(.CW(8), .RESP_LATENCY(3), .XW(12), .BAR_LOG2(2), .CHK_LOG2(1)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
    .scroll_step(scroll_step), .bus(ifb), .frame_cnt(fc_b)
  );

  // Reference model: pixel position, frame settings and per-cycle history of
  // the colour produced by the most recent request.
  int          mx, my, mmode, mfc, cyc;
  logic [7:0]  moff_next, moff_frame, mstep;
  logic [23:0] mrgb;
  logic [23:0] hist  [8192];
  bit          vhist [8192];

  function automatic logic [23:0] bar_colour(input int i);
    case (i)
      0: return 24'hFFFFFF;  1: return 24'hFFFF00;
      2: return 24'h00FFFF;  3: return 24'h00FF00;
      4: return 24'hFF00FF;  5: return 24'hFF0000;
      6: return 24'h0000FF;  default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] hc(input int t);
    return (t < 0) ? 24'h0 : hist[t];
  endfunction

  function automatic bit hv(input int t);
    return (t < 0) ? 1'b0 : vhist[t];
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mmode = 0; mfc = 0; cyc = 0;
    moff_next = 8'h0; moff_frame = 8'h0; mstep = 8'h0; mrgb = 24'h0;
  endtask

  task automatic model_update(input bit en, input bit sof, input bit sol);
    int xn, yn, me;
    logic [23:0] c, rgbv;
    logic [7:0]  stepv, offv, gv;
    if (en) begin
      xn    = (sof || sol) ? 0 : ((mx < 4095) ? mx + 1 : 4095);
      yn    = sof ? 0 : (sol ? ((my < 4095) ? my + 1 : 4095) : my);
      me    = sof ? int'(mode) : mmode;
      rgbv  = sof ? solid_rgb : mrgb;
      stepv = sof ? scroll_step : mstep;
      offv  = sof ? moff_next : moff_frame;
      gv    = 8'((int'(offv) + xn + yn) % 256);
      case (me)
        0:       c = {gv, ~gv, gv};
        1:       c = bar_colour((xn / 4) % 8);
        2:       c = (((xn / 2) + (yn / 2)) % 2 == 1) ? 24'h000000 : 24'hFFFFFF;
        default: c = rgbv;
      endcase
      mx = xn; my = yn;
      if (sof) begin
        mmode = me; mrgb = rgbv; mstep = stepv;
        moff_frame = moff_next;
        moff_next  = moff_next + stepv;
        mfc = (mfc + 1) % 65536;
      end
      hist[cyc] = c;
    end else begin
      hist[cyc] = hc(cyc - 1);
    end
    vhist[cyc] = en;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int t;
    t = cyc - 1;
    chk("a_rgb",   {8'h0, ifa.resp_red, ifa.resp_green, ifa.resp_blue}, {8'h0, hc(t)});
    chk("a_valid", 32'(ifa.resp_valid), 32'(hv(t)));
    chk("a_fcnt",  32'(fc_a), 32'(mfc));
    chk("b_rgb",   {8'h0, ifb.resp_red, ifb.resp_green, ifb.resp_blue}, {8'h0, hc(t - 2)});
    chk("b_valid", 32'(ifb.resp_valid), 32'(hv(t - 2)));
    chk("b_fcnt",  32'(fc_b), 32'(mfc));
  endtask

  task automatic step(input bit en, input bit sof, input bit sol);
    ifa.req_en = en; ifa.req_sof = sof; ifa.req_sol = sol;
    ifb.req_en = en; ifb.req_sof = sof; ifb.req_sol = sol;
    @(posedge clk);
    model_update(en, sof, sol && !sof);
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, {7'h0, ifa.resp_valid, ifa.resp_red, ifa.resp_green, ifa.resp_blue}, 32'h0);
    chk({tag, "_b"}, {7'h0, ifb.resp_valid, ifb.resp_red, ifb.resp_green, ifb.resp_blue}, 32'h0);
    chk({tag, "_fc"}, {fc_a, fc_b}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 2'd0; solid_rgb = 24'h0; scroll_step = 8'h0;
    ifa.req_en = 0; ifa.req_sof = 0; ifa.req_sol = 0;
    ifb.req_en = 0; ifb.req_sof = 0; ifb.req_sol = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Scroll gradient, step 1
    mode = 2'd0; scroll_step = 8'd1;
    step(1, 1, 0); chk("scroll_r0", 32'(ifa.resp_red), 32'h00); chk("scroll_g0", 32'(ifa.resp_green), 32'hFF);
    step(1, 0, 0); chk("scroll_r1", 32'(ifa.resp_red), 32'h01); chk("scroll_g1", 32'(ifa.resp_green), 32'hFE);
    step(1, 0, 0); chk("scroll_r2", 32'(ifa.resp_red), 32'h02);
    step(1, 0, 0); chk("scroll_r3", 32'(ifa.resp_red), 32'h03); chk("scroll_g3", 32'(ifa.resp_green), 32'hFC);
    step(1, 1, 0); chk("scroll_f2", 32'(ifa.resp_red), 32'h01);
    step(1, 0, 1); chk("scroll_sol", 32'(ifa.resp_red), 32'h02);

    // Colour bars across one line
    mode = 2'd1;
    for (int x = 0; x <= 32; x++) begin
      step(1, x == 0, 0);
      if (x <= 3) chk("bars_white", 32'({ifa.resp_red, ifa.resp_green, ifa.resp_blue}), 32'hFFFFFF);
      if (x == 4) chk("bars_x4", 32'({ifa.resp_red, ifa.resp_green, ifa.resp_blue}), 32'hFFFF00);
      if (x == 20) chk("bars_x20", 32'({ifa.resp_red, ifa.resp_green, ifa.resp_blue}), 32'hFF0000);
      if (x == 28) chk("bars_x28", 32'({ifa.resp_red, ifa.resp_green, ifa.resp_blue}), 32'h000000);
      if (x == 32) chk("bars_x32", 32'({ifa.resp_red, ifa.resp_green, ifa.resp_blue}), 32'hFFFFFF);
    end

    // Checkerboard
    mode = 2'd2;
    step(1, 1, 0); chk("chk_00", 32'({ifa.resp_red, ifa.resp_green, ifa.resp_blue}), 32'hFFFFFF);
    step(1, 0, 0);
    step(1, 0, 0); chk("chk_20", 32'({ifa.resp_red, ifa.resp_green, ifa.resp_blue}), 32'h000000);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0); chk("chk_22", 32'({ifa.resp_red, ifa.resp_green, ifa.resp_blue}), 32'hFFFFFF);

    // Mid-frame switch to solid takes effect only at the next frame
    mode = 2'd0; scroll_step = 8'd3;
    step(1, 1, 0);
    step(1, 0, 0);
    mode = 2'd3; solid_rgb = 24'h123456;
    step(1, 0, 0);
    step(1, 0, 1);
    chk("midframe_grad", 32'(ifa.resp_red == ~ifa.resp_green), 32'h1);
    step(1, 1, 0); chk("solid_sof", 32'({ifa.resp_red, ifa.resp_green, ifa.resp_blue}), 32'h123456);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 1); chk("solid_line", 32'({ifa.resp_red, ifa.resp_green, ifa.resp_blue}), 32'h123456);

    // Long line: column counter saturates
    mode = 2'd0; scroll_step = 8'd5;
    step(1, 1, 0);
    for (int i = 0; i < 4100; i++) step(1, 0, 0);

    // Randomized traffic with gaps and configuration changes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        mode        = 2'($urandom_range(0, 3));
        solid_rgb   = 24'($urandom);
        scroll_step = 8'($urandom);
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset mid-frame
    step(1, 1, 0);
    step(1, 0, 0);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mode = 2'd0; scroll_step = 8'd7;
    step(1, 1, 0); chk("rst_r00", 32'(ifa.resp_red), 32'h00);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    step(1, 1, 0); chk("rst_f2", 32'(ifa.resp_red), 32'h07);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
